// File: rtl/axi_txn_scheduler.sv
// Round-robin scheduler sharing one AXI4 burst master between NUM_REQ requesters.
// Adds a WAIT watchdog, a post-completion gap and saturating txn/error counters.
module axi_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int GAP_CYCLES     = 2,
  parameter int CNT_W          = 16,
  localparam int SW            = $clog2(NUM_REQ)
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [NUM_REQ-1:0] ACK,
  output logic               ERR,
  output logic               TOUT,
  output logic [SW-1:0]      M_SEL,
  output logic               M_INIT_AXI_TXN,
  input  logic               M_TXN_DONE,
  input  logic               M_ERROR,
  output logic               BUSY,
  output logic [CNT_W-1:0]   TXN_COUNT,
  output logic [CNT_W-1:0]   ERR_COUNT
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam int            TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int            GW     = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]    state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] pick;
  logic          pick_vld;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic          done_q;
  logic          done_rise;
  int            j;

  // Scan offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    j        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (REQ[j]) begin
        pick     = SW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  // done_q tracks the level continuously so a done left high by the
  // previous transaction never looks like a fresh rise in WAIT.
  assign done_rise = M_TXN_DONE & ~done_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state          <= S_IDLE;
      ptr            <= '0;
      tcnt           <= '0;
      gcnt           <= '0;
      done_q         <= 1'b0;
      GNT            <= '0;
      ACK            <= '0;
      ERR            <= 1'b0;
      TOUT           <= 1'b0;
      M_SEL          <= '0;
      M_INIT_AXI_TXN <= 1'b0;
      BUSY           <= 1'b0;
      TXN_COUNT      <= '0;
      ERR_COUNT      <= '0;
    end else begin
      done_q <= M_TXN_DONE;
      case (state)
        S_IDLE: if (pick_vld) begin
          state          <= S_INIT;
          GNT            <= NUM_REQ'(1) << pick;
          M_SEL          <= pick;
          M_INIT_AXI_TXN <= 1'b1;
          BUSY           <= 1'b1;
        end
        S_INIT: begin
          state          <= S_WAIT;
          M_INIT_AXI_TXN <= 1'b0;
          tcnt           <= '0;
          ptr            <= (M_SEL == SW'(NUM_REQ - 1)) ? '0 : M_SEL + SW'(1);
        end
        S_WAIT: begin
          // done on the final watchdog cycle still counts as success
          if (done_rise || tcnt == T_LAST) begin
            state <= S_RESP;
            ACK   <= GNT;
            ERR   <= done_rise ? M_ERROR : 1'b1;
            TOUT  <= ~done_rise;
            if (TXN_COUNT != '1) TXN_COUNT <= TXN_COUNT + CNT_W'(1);
            if ((~done_rise | M_ERROR) && ERR_COUNT != '1)
              ERR_COUNT <= ERR_COUNT + CNT_W'(1);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_RESP: begin
          GNT  <= '0;
          ACK  <= '0;
          ERR  <= 1'b0;
          TOUT <= 1'b0;
          gcnt <= '0;
          if (GAP_CYCLES > 0) begin
            state <= S_GAP;
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        S_GAP: begin
          if (gcnt == G_LAST) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Bench for axi_txn_scheduler: directed plan steps plus randomized transactions
// checked against a transaction-level round-robin / counter model.
module tb_axi_txn_scheduler;
  localparam int N   = 4;
  localparam int TO  = 32;
  localparam int GAP = 2;

  logic         tb_ACLK = 1'b0;
  logic         ARESETN;
  logic [N-1:0] REQ, GNT, ACK;
  logic         ERR, TOUT, M_INIT_AXI_TXN, M_TXN_DONE, M_ERROR, BUSY;
  logic [1:0]   M_SEL;
  logic [15:0]  TXN_COUNT, ERR_COUNT;

  axi_txn_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .REQ(REQ), .GNT(GNT), .ACK(ACK), .ERR(ERR),
    .TOUT(TOUT), .M_SEL(M_SEL), .M_INIT_AXI_TXN(M_INIT_AXI_TXN), .M_TXN_DONE(M_TXN_DONE),
    .M_ERROR(M_ERROR), .BUSY(BUSY), .TXN_COUNT(TXN_COUNT), .ERR_COUNT(ERR_COUNT));

  always #5 tb_ACLK = ~tb_ACLK;

  int cyc = 0;
  always @(posedge tb_ACLK) cyc <= cyc + 1;

  int nchk = 0, npass = 0;
  int m_ptr = 0, m_txn = 0, m_err = 0;
  int last_ack_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One transaction: dly = cycles after the init pulse at which the master
  // raises done (0 = never). stale keeps done high into WAIT and drops it at fall_at.
  task automatic do_txn(input logic [N-1:0] req, input int dly, input bit merr,
                        input bit drop, input bit stale, input int fall_at, input bit chk_gap);
    int  ei, n, ack_at;
    bit  got, tmo, bad;
    logic [N-1:0] eg;
    ei  = rr_pick(req);
    eg  = N'(1) << ei;
    REQ = req;
    n = 0; got = 0;
    while (n < 60 && !got) begin
      @(negedge tb_ACLK); n++;
      if (M_INIT_AXI_TXN) got = 1;
    end
    check("init_seen", 64'(got), 64'(1));
    if (!got) return;
    if (chk_gap) check("gap_len", 64'(cyc - last_ack_cyc - 1), 64'(GAP + 1));
    m_ptr = (ei + 1) % N;
    check("gnt", 64'(GNT), 64'(eg));
    check("m_sel", 64'(M_SEL), 64'(ei));
    if (!stale) M_TXN_DONE = 1'b0;
    M_ERROR = 1'b0;
    if (drop) REQ = '0;
    tmo    = (dly == 0) || (dly > TO);
    ack_at = tmo ? TO + 1 : dly + 1;
    bad    = 0;
    for (int k = 1; k < ack_at; k++) begin
      @(negedge tb_ACLK);
      if (k == 1) check("init_pulse", 64'(M_INIT_AXI_TXN), 64'(0));
      if (ACK != '0 || GNT != eg || M_SEL != 2'(ei) || M_INIT_AXI_TXN || !BUSY) bad = 1;
      if (stale && k == fall_at) M_TXN_DONE = 1'b0;
      if (!tmo && k == dly) begin M_TXN_DONE = 1'b1; M_ERROR = merr; end
    end
    @(negedge tb_ACLK);
    check("wait_phase", 64'(bad), 64'(0));
    check("ack", 64'(ACK), 64'(eg));
    check("err", 64'(ERR), 64'(tmo ? 1'b1 : merr));
    check("tout", 64'(TOUT), 64'(tmo));
    last_ack_cyc = cyc;
    m_txn++;
    if (tmo || merr) m_err++;
    @(negedge tb_ACLK);
    check("ack_clear", 64'({ACK, GNT, ERR, TOUT}), 64'(0));
    check("busy_gap", 64'(BUSY), 64'(1));
    check("txn_count", 64'(TXN_COUNT), 64'(m_txn));
    check("err_count", 64'(ERR_COUNT), 64'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rq;
    int  dl, k;
    bit  me, dr, got, bad;

    ARESETN = 1'b0; REQ = '0; M_TXN_DONE = 1'b0; M_ERROR = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    check("reset_outs", 64'({GNT, ACK, ERR, TOUT, M_SEL, M_INIT_AXI_TXN, BUSY, TXN_COUNT, ERR_COUNT}), 64'(0));
    ARESETN = 1'b1;
    @(negedge tb_ACLK);

    // round robin, all requesting: order follows 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) do_txn(4'hF, 6, 0, 0, 0, 0, i > 0);
    do_txn(4'b0010, 20, 0, 0, 0, 0, 1);   // single request
    do_txn(4'b0100, 7,  1, 0, 0, 0, 1);   // master error
    do_txn(4'b1000, 0,  0, 0, 0, 0, 1);   // watchdog expires
    do_txn(4'b0001, TO, 0, 0, 0, 0, 1);   // done on last watchdog cycle
    do_txn(4'b0010, 8,  0, 0, 1, 3, 1);   // stale done held into WAIT
    do_txn(4'b0100, 5,  0, 1, 0, 0, 1);   // REQ dropped after grant

    for (int i = 0; i < 24; i++) begin
      rq = N'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) dl = $urandom_range(TO - 1, TO + 4);
      else                           dl = $urandom_range(1, TO - 2);
      me = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      do_txn(rq, dl, me, dr, 0, 0, 1);
    end

    // reset in the middle of WAIT
    REQ = 4'b0100;
    k = 0; got = 0;
    while (k < 60 && !got) begin
      @(negedge tb_ACLK); k++;
      if (M_INIT_AXI_TXN) got = 1;
    end
    check("rst_init_seen", 64'(got), 64'(1));
    M_TXN_DONE = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    ARESETN = 1'b0;
    #1;
    check("rst_async_outs", 64'({GNT, ACK, ERR, TOUT, M_SEL, M_INIT_AXI_TXN, BUSY, TXN_COUNT, ERR_COUNT}), 64'(0));
    REQ = '0;
    bad = 0;
    repeat (3) begin
      @(negedge tb_ACLK);
      if (ACK != '0 || GNT != '0 || BUSY) bad = 1;
    end
    check("rst_hold_quiet", 64'(bad), 64'(0));
    ARESETN = 1'b1;
    @(negedge tb_ACLK);
    check("rst_counts", 64'({TXN_COUNT, ERR_COUNT}), 64'(0));
    m_ptr = 0; m_txn = 0; m_err = 0;
    do_txn(4'hF, 5, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
